// File: rtl/player_pkg.sv
// Shared types and helpers for the player lane controller family.
package player_pkg;

  typedef enum logic [1:0] {DIR_NONE, DIR_LEFT, DIR_RIGHT} dir_t;
  typedef enum logic [1:0] {RPT_IDLE, RPT_HOLD, RPT_REPEAT} rpt_state_t;

  function automatic int cnt_w(input int delay, input int rate);
    int m;
    m = (delay > rate) ? delay : rate;
    return $clog2(m + 1);
  endfunction

  // Opposing buttons cancel each other out.
  function automatic dir_t decode_dir(input logic l, input logic r);
    case ({l, r})
      2'b10:   return DIR_LEFT;
      2'b01:   return DIR_RIGHT;
      default: return DIR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/lane_step.sv
// Combinational single-lane move: next position plus moved/blocked flags.
module lane_step import player_pkg::*; #(
  parameter int NUM_LANES = 3,
  parameter int POS_W     = 5,
  parameter int WRAP      = 0
) (
  input  logic [POS_W-1:0] pos,
  input  dir_t             dir,
  output logic [POS_W-1:0] next_pos,
  output logic             moved,
  output logic             blocked
);

  localparam logic [POS_W-1:0] LAST = POS_W'(NUM_LANES - 1);

  always_comb begin
    next_pos = pos;
    moved    = 1'b0;
    blocked  = 1'b0;
    case (dir)
      DIR_LEFT: begin
        if (pos == LAST) begin
          if (WRAP != 0) begin
            next_pos = '0;
            moved    = 1'b1;
          end else begin
            blocked  = 1'b1;
          end
        end else begin
          next_pos = pos + 1'b1;
          moved    = 1'b1;
        end
      end
      DIR_RIGHT: begin
        if (pos == '0) begin
          if (WRAP != 0) begin
            next_pos = LAST;
            moved    = 1'b1;
          end else begin
            blocked  = 1'b1;
          end
        end else begin
          next_pos = pos - 1'b1;
          moved    = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/player_lane_ctrl.sv
// Player lane controller: press edge detect, one-deep pending move, hold-to-repeat.
module player_lane_ctrl import player_pkg::*; #(
  parameter int NUM_LANES    = 3,
  parameter int POS_W        = 5,
  parameter int WRAP         = 0,
  parameter int START_LANE   = NUM_LANES / 2,
  parameter int REPEAT_DELAY = 8,
  parameter int REPEAT_RATE  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             game_Over,
  input  logic             update_player,
  input  logic             left,
  input  logic             right,
  output logic [POS_W-1:0] player_pos,
  output logic             moved,
  output logic             blocked,
  output logic             at_left_edge,
  output logic             at_right_edge
);

  localparam int CW = cnt_w(REPEAT_DELAY, REPEAT_RATE);
  localparam logic [CW-1:0] DELAY_LD = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RATE_LD  = CW'(REPEAT_RATE - 1);

  logic [POS_W-1:0] pos_q, pos_d, step_pos;
  logic             moved_q, moved_d, blocked_q, blocked_d;
  logic             step_mv, step_bk;
  dir_t             dir, prev_dir_q, prev_dir_d, pending_q, pending_d;
  dir_t             press_req, req;
  rpt_state_t       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             tick, new_press, rpt_fire;

  always_comb begin
    dir        = decode_dir(left, right);
    prev_dir_d = dir;
    tick       = update_player & ~game_Over;
    new_press  = (dir != DIR_NONE) && (dir != prev_dir_q);
    press_req  = new_press ? dir : pending_q;
    rpt_fire   = (state_q != RPT_IDLE) && (cnt_q == '0);
    req        = DIR_NONE;
    if (tick) begin
      if (press_req != DIR_NONE) req = press_req;
      else if (rpt_fire)         req = dir;
    end
  end

  lane_step #(
    .NUM_LANES (NUM_LANES),
    .POS_W     (POS_W),
    .WRAP      (WRAP)
  ) u_step (
    .pos      (pos_q),
    .dir      (req),
    .next_pos (step_pos),
    .moved    (step_mv),
    .blocked  (step_bk)
  );

  always_comb begin
    pos_d     = step_pos;
    moved_d   = step_mv;
    blocked_d = step_bk;

    // A press arriving with the tick is consumed directly, so the buffer empties too.
    pending_d = pending_q;
    if (game_Over || tick) pending_d = DIR_NONE;
    else if (new_press)    pending_d = dir;

    state_d = state_q;
    cnt_d   = cnt_q;
    if (game_Over || dir == DIR_NONE) begin
      state_d = RPT_IDLE;
      cnt_d   = '0;
    end else if (tick) begin
      if (press_req != DIR_NONE) begin
        if (press_req == dir) begin
          state_d = RPT_HOLD;
          cnt_d   = DELAY_LD;
        end else begin
          state_d = RPT_IDLE;
          cnt_d   = '0;
        end
      end else if (state_q != RPT_IDLE) begin
        if (cnt_q == '0) begin
          state_d = RPT_REPEAT;
          cnt_d   = RATE_LD;
        end else begin
          cnt_d   = cnt_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pos_q      <= POS_W'(START_LANE);
      moved_q    <= 1'b0;
      blocked_q  <= 1'b0;
      prev_dir_q <= DIR_NONE;
      pending_q  <= DIR_NONE;
      state_q    <= RPT_IDLE;
      cnt_q      <= '0;
    end else begin
      pos_q      <= pos_d;
      moved_q    <= moved_d;
      blocked_q  <= blocked_d;
      prev_dir_q <= prev_dir_d;
      pending_q  <= pending_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
    end
  end

  assign player_pos    = pos_q;
  assign moved         = moved_q;
  assign blocked       = blocked_q;
  assign at_left_edge  = (pos_q == POS_W'(NUM_LANES - 1));
  assign at_right_edge = (pos_q == '0);

endmodule

// File: tb/tb_player_lane_ctrl.sv
// Scenario bench for player_lane_ctrl: a clamping and a wrapping instance share stimulus.
module tb_player_lane_ctrl;

  typedef struct packed {
    logic [4:0] pos;
    logic       mv, bk, le, re;
  } obs_t;

  typedef struct packed {
    logic l, r, u, g;
    obs_t e;
  } row_t;

  logic clk = 1'b0, reset = 1'b0;
  logic game_Over = 1'b0, update_player = 1'b0, left = 1'b0, right = 1'b0;
  logic [4:0] pos_a, pos_w;
  logic mv_a, bk_a, le_a, re_a, mv_w, bk_w, le_w, re_w;
  obs_t obs_a, obs_w, exp_o;
  obs_t sb_q[$];
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  player_lane_ctrl #(.NUM_LANES(3), .POS_W(5), .WRAP(0), .START_LANE(1),
                     .REPEAT_DELAY(2), .REPEAT_RATE(1)) u_dut (
    .clk(clk), .reset(reset), .game_Over(game_Over), .update_player(update_player),
    .left(left), .right(right), .player_pos(pos_a), .moved(mv_a), .blocked(bk_a),
    .at_left_edge(le_a), .at_right_edge(re_a));

  player_lane_ctrl #(.NUM_LANES(3), .POS_W(5), .WRAP(1), .START_LANE(1),
                     .REPEAT_DELAY(2), .REPEAT_RATE(1)) u_wrap (
    .clk(clk), .reset(reset), .game_Over(game_Over), .update_player(update_player),
    .left(left), .right(right), .player_pos(pos_w), .moved(mv_w), .blocked(bk_w),
    .at_left_edge(le_w), .at_right_edge(re_w));

  always_comb obs_a = {pos_a, mv_a, bk_a, le_a, re_a};
  always_comb obs_w = {pos_w, mv_w, bk_w, le_w, re_w};

  function automatic obs_t mk(input int p, input bit mv, input bit bk);
    return {5'(p), mv, bk, (p == 2), (p == 0)};
  endfunction

  function automatic row_t rw(input bit l, input bit r, input bit u, input bit g,
                              input int p, input bit mv, input bit bk);
    return {l, r, u, g, mk(p, mv, bk)};
  endfunction

  task automatic drive(input row_t x);
    left = x.l; right = x.r; update_player = x.u; game_Over = x.g;
    sb_q.push_back(x.e);
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    left = 0; right = 0; update_player = 0; game_Over = 0;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    apply_reset();
    tests++;
    if (obs_a !== mk(1, 0, 0)) begin
      fails++; $display("FAIL reset_clamp got %h want %h", obs_a, mk(1, 0, 0));
    end
    tests++;
    if (obs_w !== mk(1, 0, 0)) begin
      fails++; $display("FAIL reset_wrap got %h want %h", obs_w, mk(1, 0, 0));
    end
  endtask

  task automatic test_tap_left();
    row_t rows [6];
    apply_reset();
    rows = '{rw(1,0,0,0, 1,0,0), rw(0,0,0,0, 1,0,0), rw(0,0,1,0, 2,1,0),
             rw(0,0,0,0, 2,0,0), rw(0,0,1,0, 2,0,0), rw(0,0,1,0, 2,0,0)};
    for (int i = 0; i < 6; i++) begin
      drive(rows[i]);
      exp_o = sb_q.pop_front();
      tests++;
      if (obs_a !== exp_o) begin
        fails++; $display("FAIL tap_left[%0d] got %h want %h", i, obs_a, exp_o);
      end
    end
  endtask

  // Hold right into the edge, reverse into a left repeat, then reset asynchronously.
  task automatic test_hold_repeat();
    row_t rows [10];
    row_t post [3];
    apply_reset();
    rows = '{rw(0,1,0,0, 1,0,0), rw(0,1,1,0, 0,1,0), rw(0,1,0,0, 0,0,0),
             rw(0,1,1,0, 0,0,0), rw(0,1,1,0, 0,0,1), rw(0,1,0,0, 0,0,0),
             rw(0,1,1,0, 0,0,1), rw(1,0,1,0, 1,1,0), rw(1,0,1,0, 1,0,0),
             rw(1,0,1,0, 2,1,0)};
    for (int i = 0; i < 10; i++) begin
      drive(rows[i]);
      exp_o = sb_q.pop_front();
      tests++;
      if (obs_a !== exp_o) begin
        fails++; $display("FAIL hold_repeat[%0d] got %h want %h", i, obs_a, exp_o);
      end
    end
    #2 reset = 1'b0;
    #1;
    tests++;
    if (obs_a !== mk(1, 0, 0)) begin
      fails++; $display("FAIL async_reset got %h want %h", obs_a, mk(1, 0, 0));
    end
    #1 reset = 1'b1;
    post = '{rw(1,0,1,0, 2,1,0), rw(1,0,1,0, 2,0,0), rw(1,0,1,0, 2,0,1)};
    for (int i = 0; i < 3; i++) begin
      drive(post[i]);
      exp_o = sb_q.pop_front();
      tests++;
      if (obs_a !== exp_o) begin
        fails++; $display("FAIL post_reset[%0d] got %h want %h", i, obs_a, exp_o);
      end
    end
  endtask

  task automatic test_wrap();
    row_t rows [5];
    apply_reset();
    rows = '{rw(1,0,1,0, 2,1,0), rw(0,0,0,0, 2,0,0), rw(1,0,1,0, 0,1,0),
             rw(0,0,1,0, 0,0,0), rw(0,1,1,0, 2,1,0)};
    for (int i = 0; i < 5; i++) begin
      drive(rows[i]);
      exp_o = sb_q.pop_front();
      tests++;
      if (obs_w !== exp_o) begin
        fails++; $display("FAIL wrap[%0d] got %h want %h", i, obs_w, exp_o);
      end
    end
  endtask

  task automatic test_both_pressed();
    row_t rows [6];
    row_t both [3];
    apply_reset();
    rows = '{rw(1,0,0,0, 1,0,0), rw(1,1,0,0, 1,0,0), rw(1,1,1,0, 2,1,0),
             rw(1,1,1,0, 2,0,0), rw(1,1,1,0, 2,0,0), rw(1,0,1,0, 2,0,1)};
    for (int i = 0; i < 6; i++) begin
      drive(rows[i]);
      exp_o = sb_q.pop_front();
      tests++;
      if (obs_a !== exp_o) begin
        fails++; $display("FAIL pending_both[%0d] got %h want %h", i, obs_a, exp_o);
      end
    end
    apply_reset();
    both = '{rw(1,1,0,0, 1,0,0), rw(1,1,1,0, 1,0,0), rw(0,0,1,0, 1,0,0)};
    for (int i = 0; i < 3; i++) begin
      drive(both[i]);
      exp_o = sb_q.pop_front();
      tests++;
      if (obs_a !== exp_o) begin
        fails++; $display("FAIL both_initial[%0d] got %h want %h", i, obs_a, exp_o);
      end
    end
  endtask

  task automatic test_game_over();
    row_t rows [14];
    apply_reset();
    rows = '{rw(1,0,0,1, 1,0,0), rw(1,0,1,1, 1,0,0), rw(1,0,1,1, 1,0,0),
             rw(1,0,1,0, 1,0,0), rw(1,0,1,0, 1,0,0), rw(0,0,0,0, 1,0,0),
             rw(1,0,1,0, 2,1,0), rw(1,0,1,0, 2,0,0), rw(1,0,1,1, 2,0,0),
             rw(1,0,1,0, 2,0,0), rw(0,0,0,0, 2,0,0), rw(0,1,0,0, 2,0,0),
             rw(0,0,0,1, 2,0,0), rw(0,0,1,0, 2,0,0)};
    for (int i = 0; i < 14; i++) begin
      drive(rows[i]);
      exp_o = sb_q.pop_front();
      tests++;
      if (obs_a !== exp_o) begin
        fails++; $display("FAIL game_over[%0d] got %h want %h", i, obs_a, exp_o);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_tap_left();
    test_hold_repeat();
    test_wrap();
    test_both_pressed();
    test_game_over();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/player_lane_ctrl.md
Name: player_lane_ctrl

Overview:
- Parametrised player-position controller for the dodge game; replaces the fixed 3-column player block.
- Converts raw left/right button levels into lane moves with press edge detection, a one-deep pending-move buffer, and hold-to-auto-repeat.
- Supports configurable lane count and optional wrap-around.
- Sits between the input synchronisers and the board/collision logic; moves are applied only on update_player ticks.

Parameters:
- NUM_LANES, 3: number of player lanes (>=2); lane 0 = rightmost, increasing to the left.
- POS_W, 5: width of player_pos; must hold NUM_LANES-1.
- WRAP, 0: 0 = clamp at the edges; 1 = wrap from the leftmost lane to lane 0 and back.
- START_LANE, NUM_LANES/2: lane loaded on reset.
- REPEAT_DELAY, 8: update ticks a direction must be held after the first move before auto-repeat begins (>=1).
- REPEAT_RATE, 3: update ticks between auto-repeat moves (>=1).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (0 = reset)
- game_Over  in  1  1 = game over; freezes the player
- update_player  in  1  single-cycle game tick strobe
- left  in  1  move-left button level
- right  in  1  move-right button level
- player_pos  out  POS_W  current lane
- moved  out  1  one-cycle pulse; player_pos changed this cycle
- blocked  out  1  one-cycle pulse; a move was refused at an edge (WRAP=0 only)
- at_left_edge  out  1  player_pos == NUM_LANES-1
- at_right_edge  out  1  player_pos == 0

Behaviour:
- Reset (asynchronous, active-low) values: player_pos=START_LANE, moved=0, blocked=0, state=IDLE, pending=NONE, prev_dir=NONE, counter=0. at_left_edge and at_right_edge are decoded combinationally from player_pos.
- Direction decode: {left,right}=10 gives LEFT; 01 gives RIGHT; 00 and 11 give NONE.
- prev_dir is registered every clk.
- new_press = (dir != NONE) && (dir != prev_dir).
- Pending buffer: on new_press, pending <= dir, overwriting any older value. It is cleared when consumed on a tick. A new_press in the same cycle as a tick is consumed directly by that tick.
- Tick = update_player && !game_Over. On a non-tick cycle, only prev_dir and pending may change.
- Move request on a tick = new_press ? dir : pending. If there is no such request, the request comes from the repeat FSM.
- Applying a move:
  - LEFT: pos+1.
  - RIGHT: pos-1.
  - At an edge with WRAP=0: position unchanged, blocked=1 for one cycle.
  - At an edge with WRAP=1: LEFT at NUM_LANES-1 goes to 0; RIGHT at 0 goes to NUM_LANES-1.
  - A successful move sets moved=1 for one cycle.
- Latency: player_pos, moved and blocked update on the clk edge that samples the tick, i.e. registered one cycle after update_player is presented.
- Repeat FSM, states IDLE, HOLD, REPEAT. Counters are decremented on ticks only, never on raw clocks.
  - IDLE: a tick that applies a press/pending move, with dir still held -> HOLD, counter=REPEAT_DELAY-1.
  - HOLD, dir == the held direction, on tick: if counter==0, apply move, go to REPEAT, counter=REPEAT_RATE-1; else counter-1.
  - REPEAT, same rules: on counter==0, apply move and reload REPEAT_RATE-1.
  - dir becomes NONE (including 11) -> IDLE, counter=0, any clk.
  - dir changes to the opposite direction -> handled as a new_press; the FSM restarts from that move into HOLD.
  - A blocked move still counts as a move for FSM timing.
- game_Over=1: player_pos frozen, pending cleared, FSM forced to IDLE, moved=blocked=0. Presses during game_Over are discarded. On release, a still-held button is not a new press.
- Reset asserted mid-hold or mid-repeat: all state returns to reset values immediately, with no clock required.

Decomposition:
- Package player_pkg:
  - dir_t enum {DIR_NONE, DIR_LEFT, DIR_RIGHT}.
  - rpt_state_t enum {RPT_IDLE, RPT_HOLD, RPT_REPEAT}.
  - Counter width function: $clog2(max(REPEAT_DELAY,REPEAT_RATE)+1).
- One sub-module, lane_step: combinational next-position, blocked and moved computation from (pos, dir, WRAP, NUM_LANES). Reused by later multi-player variants.

Test Plan (NUM_LANES=3, START_LANE=1, REPEAT_DELAY=2, REPEAT_RATE=1, WRAP=0 unless stated):
1. Reset low then high, no input -> player_pos=1, moved=0, at edges=0; reset low mid-REPEAT -> player_pos=1 asynchronously.
2. Tap left for 1 clk between ticks, next tick -> player_pos=2, moved pulse; further ticks with no input -> stays 2, at_left_edge=1.
3. Hold right across ticks from pos 1:
   - tick1 -> 0 (moved).
   - tick2 -> no move (HOLD).
   - tick3 -> blocked pulse, pos 0.
   - tick4 -> blocked again.
4. WRAP=1, pos 2, tap left, tick -> player_pos=0, moved=1, blocked=0.
5. Press left, then {1,1} before the tick -> pending LEFT applied at tick (pos 2), FSM IDLE afterward; left and right pressed together initially -> no move.
6. game_Over=1 while holding left with ticks -> pos unchanged, no pulses; game_Over=0 with left still held -> no move until left is released and re-pressed.
